spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

SPI slave receiver that accepts 16-bit command frames from the AR9331 (SPI master) and stores 12-bit DAC codes into an 8-entry channel bank. The DAC polling path reads the bank by 74HC4051 position. It is the receive end of the same 16-bit MSB-first SPI framing we drive out to the AD5320. It runs in the 100 MHz PLL domain and oversamples the external SPI pins.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops on sclk, mosi and cs_n (minimum 2).
- RST_VAL, 2048: reset value of every bank entry (DAC midscale).

Ports:
- clk  in  1  system clock (CLK_100M); single clock domain.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from master, asynchronous; CPOL=0, CPHA=0; f_sclk ≤ f_clk/8.
- mosi  in  1  SPI data in, asynchronous.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- miso  out  1  SPI data out: echo of the last completed frame.
- frame_data  out  16  last completed frame.
- frame_valid  out  1  one-cycle pulse when frame_data updates.
- frame_err  out  1  one-cycle pulse when cs_n deasserts on a partial frame.
- rd_addr  in  3  bank read address (HC4051_POS).
- rd_data  out  12  bank[rd_addr], registered.

## Operation
- Frame format, MSB first: [15] wr_en, [14:12] channel, [11:0] code.
- sclk, mosi and cs_n each pass through SYNC_STAGES flops plus one history flop. The edge detects are rise = s & ~s_d and fall = ~s & s_d. mosi is delayed identically, so it stays aligned with sclk.
- State IDLE:
  - Bit counter is 0 and sclk edges are ignored.
  - On synced cs_n falling: go to RECV, clear the bit counter, load tx_shift with frame_data.
- State RECV, on each sclk rise:
  - rx_shift <= {rx_shift[14:0], mosi_s}.
  - cnt <= cnt+1 (4-bit counter, wraps 15→0).
- Frame completion (cnt == 15 at a rise):
  - Next cycle: frame_data <= completed word and frame_valid = 1.
  - If wr_en = 1, then bank[channel] <= code in that same cycle. If wr_en = 0, it is a read/no-op frame and the bank is unchanged.
  - cnt returns to 0 and tx_shift reloads with the new word. Back-to-back frames within one cs_n low are legal.
- Synced cs_n rising in RECV:
  - Return to IDLE.
  - If cnt ≠ 0, pulse frame_err for one cycle and discard rx_shift. The bank and frame_data are unchanged.
- miso:
  - Drives tx_shift[15] while in RECV and 0 in IDLE.
  - tx_shift shifts left on each sclk fall in RECV. The master therefore reads the previous frame during the current frame.
- rd_data <= bank[rd_addr] every cycle.
  - A write and a read to the same address in one cycle return the old value, then the new value on the following cycle.

## Timing
- Reset values:
  - Outputs: miso=0, frame_data=0, frame_valid=0, frame_err=0, rd_data=RST_VAL.
  - Internal: all bank entries = RST_VAL, state IDLE, cnt=0, rx_shift=tx_shift=0.
  - The synchronizer flops reset to 1 for cs_n and 0 for sclk and mosi, so a held cs_n low is seen as a falling edge after reset.
- Pin-to-detect latency is SYNC_STAGES+1 clk for every SPI input.
- Last sclk rise at pin → frame_valid: SYNC_STAGES+2 clk (4 at default). Bank write lands on the same cycle. The new value is visible on rd_data 1 clk later.
- Simultaneity rules:
  - cs_n rise detected in the same cycle as the 16th sclk rise: the frame completes (frame_valid), frame_err=0, then IDLE.
  - cs_n fall and an sclk rise in the same cycle: the rise is ignored, because CPHA=0 requires no edge before cs_n settles.
- rst during RECV aborts the frame with no frame_valid or frame_err and restores all reset values, including the bank.
- frame_valid and frame_err are never high in the same cycle.

## Test plan
- Reset, then read all 8 addresses → rd_data = 2048 for each; miso = 0; no pulses.
- One frame 0x9ABC (wr, ch1, code 0xABC) at f_clk/10 → frame_valid 4 clk after the last rise, frame_data=0x9ABC, rd_addr=1 gives 0xABC; the other channels stay at 2048.
- Two back-to-back frames 0xF123 then 0x1456 under one cs_n low → two frame_valid pulses; bank[7]=0x123; bank[1] unchanged (wr_en=0); the miso bits of the second frame equal 0xF123.
- cs_n raised after 9 bits → one frame_err pulse, no frame_valid, bank and frame_data unchanged; the next full frame 0x8005 writes bank[0]=5 correctly.
- rst asserted after 12 bits of 0xB7FF → all bank entries 2048, frame_data=0; cs_n held low and 16 new bits 0xB001 → bank[3]=1.
- cs_n rise coincident with the 16th detected sclk rise (frame 0xC0FF) → frame_valid, frame_err=0, bank[4]=0x0FF, state IDLE.

Source files
------------

// File: rtl/spi_slave_rx.sv
// ---------------------------------------------------------------------------
// spi_slave_rx
//
// SPI slave receiver (mode 0: CPOL=0, CPHA=0) for 16-bit MSB-first command
// frames from the AR9331. Each frame is laid out as:
//   [15] wr_en   [14:12] channel   [11:0] code
// A completed frame with wr_en set stores its code into an 8-entry bank of
// 12-bit DAC codes. The DAC polling path reads that bank by 74HC4051
// position. The SPI pins are asynchronous and are oversampled in the clk
// domain. sclk must be no faster than clk/8.
//
// Ports
//   clk          system clock (100 MHz PLL domain)
//   rst          synchronous active-high reset
//   sclk         SPI clock from the master (asynchronous)
//   mosi         SPI data in (asynchronous)
//   cs_n         SPI chip select, active low (asynchronous)
//   miso         SPI data out: echo of the last completed frame
//   frame_data   last completed 16-bit frame
//   frame_valid  one-cycle pulse when frame_data updates
//   frame_err    one-cycle pulse when cs_n rises on a partial frame
//   rd_addr      bank read address (HC4051 position)
//   rd_data      bank[rd_addr], registered
// ---------------------------------------------------------------------------
module spi_slave_rx #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [11:0] RST_VAL     = 12'd2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs_n,
    output logic        miso,
    output logic [15:0] frame_data,
    output logic        frame_valid,
    output logic        frame_err,
    input  logic [2:0]  rd_addr,
    output logic [11:0] rd_data
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // Input synchronizers.
    // cs_n resets to 1, so a cs_n held low through reset shows up as a
    // falling edge once reset is released.
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic w_sclk_s;
    logic w_mosi_s;
    logic w_cs_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    // mosi runs through the same synchronizer depth as sclk. At a detected
    // rise, this is the data bit the master set up before that edge.
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
    assign w_cs_rise   =  w_cs_s   & ~r_cs_d;
    assign w_cs_fall   = ~w_cs_s   &  r_cs_d;

    // ---------------------------------------------------------------------
    // Frame FSM.
    // r_done marks a 16th rise. The completed word is committed one cycle
    // later, which sets frame_valid and performs the bank write together.
    // ---------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_rx_shift;
    logic [15:0] r_tx_shift;
    logic        r_done;
    logic [15:0] r_frame_data;
    logic        r_frame_valid;
    logic        r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_rx_shift    <= 16'd0;
            r_tx_shift    <= 16'd0;
            r_done        <= 1'b0;
            r_frame_data  <= 16'd0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_done        <= 1'b0;

            if (r_done) begin
                r_frame_data  <= r_rx_shift;
                r_frame_valid <= 1'b1;
                // Reload the echo so that a back-to-back frame returns this word.
                r_tx_shift    <= r_rx_shift;
            end

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 4'd0;
                    if (w_cs_fall) begin
                        r_state <= ST_RECV;
                        if (!r_done) begin
                            r_tx_shift <= r_frame_data;
                        end
                    end
                end

                ST_RECV: begin
                    if (w_sclk_rise) begin
                        r_rx_shift <= {r_rx_shift[14:0], w_mosi_s};
                        r_cnt      <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_done <= 1'b1;
                        end
                    end else if (w_sclk_fall && (r_cnt != 4'd0) && !r_done) begin
                        // A fall with cnt == 0 is the trailing edge after
                        // the 16th rise. By then the echo has been reloaded,
                        // and shifting would lose its MSB before the next
                        // frame's first rise.
                        r_tx_shift <= {r_tx_shift[14:0], 1'b0};
                    end

                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                        // A 16th rise detected in this same cycle still
                        // completes the frame. Any other nonzero count is a
                        // truncated frame.
                        if ((r_cnt != 4'd0) && !(w_sclk_rise && (r_cnt == 4'd15))) begin
                            r_frame_err <= 1'b1;
                            r_rx_shift  <= 16'd0;
                            r_cnt       <= 4'd0;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Channel bank. It is written on the commit cycle and read through a
    // register, so a write and a read to the same entry return the old value
    // first.
    // ---------------------------------------------------------------------
    logic [11:0] r_bank [8];
    logic [11:0] r_rd_data;
    logic        w_bank_we;

    assign w_bank_we = r_done & r_rx_shift[15];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_bank[i] <= RST_VAL;
            end
            r_rd_data <= RST_VAL;
        end else begin
            if (w_bank_we) begin
                r_bank[r_rx_shift[14:12]] <= r_rx_shift[11:0];
            end
            r_rd_data <= r_bank[rd_addr];
        end
    end

    assign miso        = (r_state == ST_RECV) & r_tx_shift[15];
    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_spi_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_rx
//
// Directed and random SPI mode-0 frames at clk/10, run against a simple
// behavioural model: an 8-entry array updated per completed frame, plus the
// last-frame word.
// ---------------------------------------------------------------------------
module tb_spi_slave_rx;

    localparam int HALF = 5;   // sclk half period in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic        miso;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic [2:0]  rd_addr;
    logic [11:0] rd_data;

    spi_slave_rx #(.SYNC_STAGES(2), .RST_VAL(12'd2048)) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .miso        (miso),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    // Pulse counters
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;

    always @(posedge clk) begin
        if (frame_valid) valid_cnt <= valid_cnt + 1;
        if (frame_err)   err_cnt   <= err_cnt + 1;
        if (frame_valid && frame_err) both_cnt <= both_cnt + 1;
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference model
    logic [11:0] ref_bank [8];
    logic [15:0] ref_fd;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_bank[i] = 12'd2048;
        ref_fd = 16'd0;
    endtask

    task automatic model_frame(input logic [15:0] w);
        ref_fd = w;
        if (w[15]) ref_bank[w[14:12]] = w[11:0];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bank_check(input string tag);
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            rd_addr = 3'(a);
            @(negedge clk);
            chk($sformatf("%s bank[%0d]", tag, a), 32'(rd_data), 32'(ref_bank[a]));
        end
    endtask

    // Shift n bits of w MSB first. The bit master sees on miso before each
    // rise is collected, and so is the number of clks from the last rise to
    // frame_valid (0 if none). With cs_last set, cs_n rises together with
    // the final sclk rise.
    task automatic spi_bits(input logic [15:0] w, input int n, input bit cs_last,
                            output logic [15:0] miso_word, output int lat);
        lat       = 0;
        miso_word = 16'd0;
        for (int b = 0; b < n; b++) begin
            mosi = w[15-b];
            repeat (HALF) @(negedge clk);
            miso_word = {miso_word[14:0], miso};
            sclk = 1'b1;
            if (cs_last && (b == n-1)) cs_n = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (frame_valid && (lat == 0) && (b == n-1)) lat = k;
            end
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        repeat (2*HALF) @(negedge clk);
    endtask

    initial begin
        logic [15:0] mw;
        logic [15:0] w;
        int          lat;
        int          v0;
        int          e0;

        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; rd_addr = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: reset state
        chk("reset miso", 32'(miso), 32'd0);
        chk("reset frame_data", 32'(frame_data), 32'd0);
        chk("reset pulses", 32'(valid_cnt + err_cnt), 32'd0);
        bank_check("reset");

        // 2: single write frame, latency
        v0 = valid_cnt;
        cs_low();
        spi_bits(16'h9ABC, 16, 1'b0, mw, lat);
        model_frame(16'h9ABC);
        chk("single latency", 32'(lat), 32'd4);
        chk("single frame_data", 32'(frame_data), 32'(ref_fd));
        cs_high();
        chk("single valid count", 32'(valid_cnt - v0), 32'd1);
        bank_check("single");

        // 3: back-to-back frames under one cs_n low, miso echo
        v0 = valid_cnt;
        cs_low();
        spi_bits(16'hF123, 16, 1'b0, mw, lat);
        model_frame(16'hF123);
        chk("b2b first echo", 32'(mw), 32'h9ABC);
        spi_bits(16'h1456, 16, 1'b0, mw, lat);
        model_frame(16'h1456);
        chk("b2b second echo", 32'(mw), 32'hF123);
        chk("b2b latency", 32'(lat), 32'd4);
        cs_high();
        chk("b2b valid count", 32'(valid_cnt - v0), 32'd2);
        chk("b2b frame_data", 32'(frame_data), 32'(ref_fd));
        bank_check("b2b");

        // 4: partial frame aborted by cs_n
        v0 = valid_cnt; e0 = err_cnt;
        cs_low();
        spi_bits(16'h3777, 9, 1'b0, mw, lat);
        cs_high();
        chk("partial err count", 32'(err_cnt - e0), 32'd1);
        chk("partial valid count", 32'(valid_cnt - v0), 32'd0);
        chk("partial frame_data", 32'(frame_data), 32'(ref_fd));
        bank_check("partial");
        cs_low();
        spi_bits(16'h8005, 16, 1'b0, mw, lat);
        model_frame(16'h8005);
        cs_high();
        chk("after partial frame_data", 32'(frame_data), 32'(ref_fd));
        bank_check("after partial");

        // 5: reset in the middle of a frame, cs_n held low across it
        v0 = valid_cnt; e0 = err_cnt;
        cs_low();
        spi_bits(16'hB7FF, 12, 1'b0, mw, lat);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("midreset pulses", 32'((valid_cnt - v0) + (err_cnt - e0)), 32'd0);
        chk("midreset frame_data", 32'(frame_data), 32'd0);
        bank_check("midreset");
        spi_bits(16'hB001, 16, 1'b0, mw, lat);
        model_frame(16'hB001);
        cs_high();
        chk("postreset frame_data", 32'(frame_data), 32'(ref_fd));
        bank_check("postreset");

        // 6: cs_n rise coincident with the 16th sclk rise
        v0 = valid_cnt; e0 = err_cnt;
        cs_low();
        spi_bits(16'hC0FF, 16, 1'b1, mw, lat);
        model_frame(16'hC0FF);
        repeat (HALF) @(negedge clk);
        chk("coincident valid count", 32'(valid_cnt - v0), 32'd1);
        chk("coincident err count", 32'(err_cnt - e0), 32'd0);
        chk("coincident idle miso", 32'(miso), 32'd0);
        chk("coincident frame_data", 32'(frame_data), 32'(ref_fd));
        bank_check("coincident");

        // 7: random frames, each under its own cs_n low
        for (int r = 0; r < 8; r++) begin
            w = 16'($urandom);
            v0 = valid_cnt;
            cs_low();
            spi_bits(w, 16, 1'b0, mw, lat);
            chk($sformatf("rand%0d echo", r), 32'(mw), 32'(ref_fd));
            model_frame(w);
            cs_high();
            chk($sformatf("rand%0d latency", r), 32'(lat), 32'd4);
            chk($sformatf("rand%0d frame_data", r), 32'(frame_data), 32'(ref_fd));
            chk($sformatf("rand%0d valid count", r), 32'(valid_cnt - v0), 32'd1);
        end
        bank_check("random");

        chk("valid and err never together", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
